shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter REQ_COUNT, default 2, number of requester ports (legal 2..4).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  REQ_COUNT  per-requester request valid.
REQ-005 SHALL have port req_ready  output  REQ_COUNT  per-requester accept (one-hot or zero).
REQ-006 SHALL have port req_op  input  2*REQ_COUNT  per-requester op: 00 ROLR, 01 ROLL, 10 SHIFTR, 11 SHIFTL.
REQ-007 SHALL have port req_size  input  2*REQ_COUNT  per-requester size: 00 8b, 01 16b, 10 32b, 11 64b.
REQ-008 SHALL have port req_use_carry  input  REQ_COUNT  per-requester through-carry select.
REQ-009 SHALL have port req_carry_in  input  REQ_COUNT  per-requester carry in.
REQ-010 SHALL have port req_a  input  64*REQ_COUNT  per-requester operand.
REQ-011 SHALL have port req_b  input  8*REQ_COUNT  per-requester count.
REQ-012 SHALL have ports resp_valid output 1, resp_ready input 1: result handshake.
REQ-013 SHALL have ports resp_id output 2 (granted requester), resp_result output 64, resp_zero / resp_carry / resp_negative output 1 each.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on accept, RUN->DONE when remaining count is 0, DONE->IDLE on resp_valid & resp_ready.
REQ-016 In IDLE, SHALL grant the first valid requester at or after the round-robin pointer; req_ready of that index only is high, combinationally; accept = req_valid & req_ready.
REQ-017 On accept, pointer SHALL become (grant+1) mod REQ_COUNT; no request accepted outside IDLE.
REQ-018 On accept, SHALL latch operands, zero-extend a above size, and load count: rotates b mod W (W+1 with carry), shifts min(b, W) (min(b, W+1) with carry), W = size width.
REQ-019 In RUN, SHALL move one bit per cycle and decrement count by 1; count 0 at accept still spends one RUN cycle, so resp_valid rises exactly count+1 cycles after the accept edge.
REQ-020 ROLR/ROLL SHALL rotate within W bits, or W+1 bits including carry when use_carry; shifts SHALL fill vacated bit with carry if use_carry else 0.
REQ-021 Carry SHALL be last bit moved out (rotate without carry: bit wrapped); count 0 SHALL leave carry = carry_in.
REQ-022 In DONE: resp_zero = (result[W-1:0]==0), resp_negative = result[W-1], result bits above W = 0; outputs held stable while resp_ready low.
REQ-023 resp_valid & resp_ready SHALL return to IDLE and permit a new accept the following cycle, not the same cycle.

Reset
REQ-024 Reset SHALL asynchronously force IDLE, pointer 0, resp_valid 0, resp_result 0, resp_id 0, flags 0, busy 0, req_ready 0 while asserted.
REQ-025 Reset mid-RUN or mid-DONE SHALL discard the operation with no response.

Configuration
REQ-026 With SHIFT_SEQ_BYTE_STEP_EN defined, RUN SHALL move 8 bits per cycle while remaining count >= 8 and use_carry is 0, else 1 bit; without it, always 1 bit per cycle; results identical in both builds.

Verification
REQ-027 Req0 ROLR 8b a=0x81 b=1 carry_in=0 -> resp_result 0xC0, carry 1, negative 1, resp_valid 2 cycles after accept.
REQ-028 Req1 SHIFTL 16b use_carry=1 carry_in=1 a=0x8000 b=1 -> result 0x0001, carry 1, zero 0.
REQ-029 Both req_valid held, 4 back-to-back ops -> grants 0,1,0,1; resp_id matches each.
REQ-030 SHIFTR 64b b=200 -> count clamped 64, result 0, zero 1; with SHIFT_SEQ_BYTE_STEP_EN, resp_valid 9 cycles after accept, else 65.
REQ-031 resp_ready low 5 cycles in DONE -> outputs stable, req_ready 0; reset in RUN -> resp_valid 0, busy 0 immediately, no response.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Request/response bundle for shift_sequencer: per-requester operand buses,
// round-robin ready, and the single result channel.
interface shift_sequencer_if #(
  parameter int REQ_COUNT = 2
);
  logic [REQ_COUNT-1:0]    req_valid;
  logic [REQ_COUNT-1:0]    req_ready;
  logic [2*REQ_COUNT-1:0]  req_op;
  logic [2*REQ_COUNT-1:0]  req_size;
  logic [REQ_COUNT-1:0]    req_use_carry;
  logic [REQ_COUNT-1:0]    req_carry_in;
  logic [64*REQ_COUNT-1:0] req_a;
  logic [8*REQ_COUNT-1:0]  req_b;

  logic                    resp_valid;
  logic                    resp_ready;
  logic [1:0]              resp_id;
  logic [63:0]             resp_result;
  logic                    resp_zero;
  logic                    resp_carry;
  logic                    resp_negative;
  logic                    busy;

  modport master (
    output req_valid, req_op, req_size, req_use_carry, req_carry_in, req_a, req_b,
    output resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_zero, resp_carry,
    input  resp_negative, busy
  );

  modport slave (
    input  req_valid, req_op, req_size, req_use_carry, req_carry_in, req_a, req_b,
    input  resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_zero, resp_carry,
    output resp_negative, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-requester bit-serial rotate/shift sequencer with round-robin arbitration.
// Optional SHIFT_SEQ_BYTE_STEP_EN: move 8 bits per cycle on long non-carry operations.
module shift_sequencer #(
  parameter int REQ_COUNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  localparam logic [1:0] OP_ROLR = 2'b00;
  localparam logic [1:0] OP_ROLL = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;

  typedef struct packed {
    logic [63:0] val;
    logic        carry;
  } stepT;

  function automatic logic [5:0] sizeMsb(input logic [1:0] size);
    case (size)
      2'd0:    sizeMsb = 6'd7;
      2'd1:    sizeMsb = 6'd15;
      2'd2:    sizeMsb = 6'd31;
      default: sizeMsb = 6'd63;
    endcase
  endfunction

  function automatic logic [63:0] sizeMask(input logic [5:0] msb);
    sizeMask = {64{1'b1}} >> (6'd63 - msb);
  endfunction

  // Rotates wrap modulo the ring length; shifts saturate once everything has been pushed out.
  function automatic logic [6:0] loadCount(input logic [1:0] op, input logic [1:0] size,
                                           input logic useCarry, input logic [7:0] b);
    logic [7:0] w;
    logic [7:0] lim;
    logic [7:0] modRing;
    w = 8'd8 << size;
    case (size)
      2'd0:    modRing = b % 8'd9;
      2'd1:    modRing = b % 8'd17;
      2'd2:    modRing = b % 8'd33;
      default: modRing = b % 8'd65;
    endcase
    if (!op[1]) begin
      loadCount = useCarry ? 7'(modRing) : 7'(b & (w - 8'd1));
    end else begin
      lim = useCarry ? w + 8'd1 : w;
      loadCount = (b > lim) ? 7'(lim) : 7'(b);
    end
  endfunction

  // Through-carry shifts fill with the latched carry_in on every step, so the
  // W+1 clamp saturates the word to carry_in.
  function automatic stepT moveOne(input logic [63:0] v, input logic c, input logic [1:0] op,
                                   input logic [5:0] msb, input logic [63:0] mask,
                                   input logic useCarry, input logic fillBit);
    stepT s;
    case (op)
      OP_ROLR: begin
        s.carry = v[0];
        s.val   = (v >> 1) | (64'(useCarry ? c : v[0]) << msb);
      end
      OP_ROLL: begin
        s.carry = v[msb];
        s.val   = ((v << 1) & mask) | 64'(useCarry ? c : v[msb]);
      end
      OP_SHR: begin
        s.carry = v[0];
        s.val   = (v >> 1) | (64'(useCarry & fillBit) << msb);
      end
      default: begin
        s.carry = v[msb];
        s.val   = ((v << 1) & mask) | 64'(useCarry & fillBit);
      end
    endcase
    return s;
  endfunction

  function automatic stepT moveByte(input logic [63:0] v, input logic [1:0] op,
                                    input logic [5:0] msb, input logic [63:0] mask);
    stepT s;
    case (op)
      OP_ROLR: begin
        s.carry = v[7];
        s.val   = (v >> 8) | (64'(v[7:0]) << (msb - 6'd7));
      end
      OP_ROLL: begin
        s.carry = v[msb - 6'd7];
        s.val   = ((v << 8) & mask) | (v >> (msb - 6'd7));
      end
      OP_SHR: begin
        s.carry = v[7];
        s.val   = v >> 8;
      end
      default: begin
        s.carry = v[msb - 6'd7];
        s.val   = (v << 8) & mask;
      end
    endcase
    return s;
  endfunction

  stateT                state;
  stateT                nextState;
  logic [1:0]           rrPtr;
  logic [1:0]           gntIdx;
  logic                 gntFound;
  logic [REQ_COUNT-1:0] gntVec;
  logic [REQ_COUNT-1:0] reqReady;
  logic                 accept;
  logic                 finish;
  logic                 byteStep;

  logic [1:0]           selOp;
  logic [1:0]           selSize;
  logic                 selUseCarry;
  logic                 selCarryIn;
  logic [63:0]          selA;
  logic [7:0]           selB;

  logic [1:0]           opReg;
  logic [1:0]           sizeReg;
  logic                 useCarryReg;
  logic                 carryInReg;
  logic [63:0]          workVal;
  logic                 workCarry;
  logic [6:0]           count;
  logic [5:0]           msb;
  logic [63:0]          mask;
  stepT                 stepNext;

  logic [1:0]           respId;
  logic [63:0]          respResult;
  logic                 respZero;
  logic                 respCarry;
  logic                 respNegative;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    gntFound = 1'b0;
    gntIdx   = '0;
    gntVec   = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      for (int j = 0; j < REQ_COUNT; j++) begin
        if (!gntFound && bus.req_valid[j] && (j == (int'(rrPtr) + i) % REQ_COUNT)) begin
          gntFound = 1'b1;
          gntIdx   = 2'(j);
        end
      end
    end
    for (int j = 0; j < REQ_COUNT; j++) begin
      gntVec[j] = gntFound && (gntIdx == 2'(j));
    end
  end

  always_comb begin
    selOp       = '0;
    selSize     = '0;
    selUseCarry = 1'b0;
    selCarryIn  = 1'b0;
    selA        = '0;
    selB        = '0;
    for (int j = 0; j < REQ_COUNT; j++) begin
      if (gntIdx == 2'(j)) begin
        selOp       = bus.req_op[2*j +: 2];
        selSize     = bus.req_size[2*j +: 2];
        selUseCarry = bus.req_use_carry[j];
        selCarryIn  = bus.req_carry_in[j];
        selA        = bus.req_a[64*j +: 64];
        selB        = bus.req_b[8*j +: 8];
      end
    end
  end

  always_comb begin
    nextState = state;
    reqReady  = '0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          reqReady = gntVec;
          if (gntFound) begin
            accept    = 1'b1;
            nextState = RUN;
          end
        end
      end
      RUN: begin
        if (count == 7'd0) begin
          finish    = 1'b1;
          nextState = DONE;
        end
      end
      DONE: begin
        if (bus.resp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rrPtr        <= '0;
      respId       <= '0;
      respResult   <= '0;
      respZero     <= 1'b0;
      respCarry    <= 1'b0;
      respNegative <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        rrPtr  <= (gntIdx == 2'(REQ_COUNT - 1)) ? 2'd0 : gntIdx + 2'd1;
        respId <= gntIdx;
      end
      if (finish) begin
        respResult   <= workVal;
        respZero     <= ((workVal & mask) == 64'd0);
        respCarry    <= workCarry;
        respNegative <= workVal[msb];
      end
    end
  end

  assign msb  = sizeMsb(sizeReg);
  assign mask = sizeMask(msb);

`ifdef SHIFT_SEQ_BYTE_STEP_EN
  assign byteStep = !useCarryReg && (count >= 7'd8);
`else
  assign byteStep = 1'b0;
`endif

  assign stepNext = byteStep ? moveByte(workVal, opReg, msb, mask)
                             : moveOne(workVal, workCarry, opReg, msb, mask, useCarryReg, carryInReg);

  // Working datapath: loaded on accept, stepped while RUN has bits left to move.
  always_ff @(posedge clk) begin
    if (accept) begin
      opReg       <= selOp;
      sizeReg     <= selSize;
      useCarryReg <= selUseCarry;
      carryInReg  <= selCarryIn;
      workVal     <= selA & sizeMask(sizeMsb(selSize));
      workCarry   <= selCarryIn;
      count       <= loadCount(selOp, selSize, selUseCarry, selB);
    end else if (state == RUN && count != 7'd0) begin
      workVal   <= stepNext.val;
      workCarry <= stepNext.carry;
      count     <= count - (byteStep ? 7'd8 : 7'd1);
    end
  end

  assign bus.req_ready     = reqReady;
  assign bus.busy          = (state != IDLE);
  assign bus.resp_valid    = (state == DONE);
  assign bus.resp_id       = respId;
  assign bus.resp_result   = respResult;
  assign bus.resp_zero     = respZero;
  assign bus.resp_carry    = respCarry;
  assign bus.resp_negative = respNegative;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: closed-form rotate/shift model, round-robin
// grant model and latency model feed a queue that is checked on every response.
module tb_shift_sequencer;
  localparam int RC = 2;

  logic clk = 1'b0;
  logic reset;

  shift_sequencer_if #(.REQ_COUNT(RC)) bus();

  shift_sequencer #(.REQ_COUNT(RC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] res;
    logic        c;
    logic        z;
    logic        n;
    int          lat;
    int          acceptCyc;
  } expT;

  expT        sb[$];
  int         errCnt    = 0;
  int         chkCnt    = 0;
  int         cyc       = 0;
  int         acceptCnt = 0;
  int         respCnt   = 0;
  logic [1:0] modelPtr  = 2'd0;
  logic       modelBusy = 1'b0;
  logic       sawValid  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic expT model(input int id, input logic [1:0] op, input logic [1:0] size,
                                input logic uc, input logic cin, input logic [63:0] a,
                                input logic [7:0] b);
    expT e;
    int w, n;
    logic [127:0] m, mw1, av, ext, r, fill;
    w   = 8 << size;
    m   = (128'd1 << w) - 128'd1;
    mw1 = (128'd1 << (w + 1)) - 128'd1;
    av  = {64'd0, a} & m;
    if (!op[1]) n = uc ? int'(b) % (w + 1) : int'(b) % w;
    else begin
      n = int'(b);
      if (uc && n > w + 1) n = w + 1;
      if (!uc && n > w) n = w;
    end
    case (op)
      2'b00, 2'b01: begin
        if (uc) begin
          ext = av | (128'(cin) << w);
          if (op == 2'b00) r = ((ext >> n) | (ext << (w + 1 - n))) & mw1;
          else             r = ((ext << n) | (ext >> (w + 1 - n))) & mw1;
          e.c = r[w];
          r   = r & m;
        end else begin
          if (op == 2'b00) r = ((av >> n) | (av << (w - n))) & m;
          else             r = ((av << n) | (av >> (w - n))) & m;
          e.c = (n == 0) ? cin : ((op == 2'b00) ? r[w-1] : r[0]);
        end
      end
      2'b10: begin
        r    = av >> n;
        fill = m & ~(m >> n);
        if (uc && cin) r = r | fill;
        e.c = (n == 0) ? cin : ((n <= w) ? av[n-1] : cin);
      end
      default: begin
        r    = (av << n) & m;
        fill = ((128'd1 << n) - 128'd1) & m;
        if (uc && cin) r = r | fill;
        e.c = (n == 0) ? cin : ((n <= w) ? av[w-n] : cin);
      end
    endcase
    e.id  = 2'(id);
    e.res = r[63:0];
    e.z   = (r == 128'd0);
    e.n   = r[w-1];
`ifdef SHIFT_SEQ_BYTE_STEP_EN
    e.lat = uc ? n + 1 : (n / 8) + (n % 8) + 1;
`else
    e.lat = n + 1;
`endif
    e.acceptCyc = 0;
    return e;
  endfunction

  // Called once per cycle at the falling edge; updates the model after checking.
  task automatic monitor();
    logic [RC-1:0] expRdy;
    expT e;
    int g;
    if (reset) begin
      sb.delete();
      modelBusy = 1'b0;
      modelPtr  = 2'd0;
      sawValid  = 1'b0;
      return;
    end
    expRdy = '0;
    g      = -1;
    if (!modelBusy) begin
      for (int i = 0; i < RC; i++) begin
        int j;
        j = (int'(modelPtr) + i) % RC;
        if (g < 0 && bus.req_valid[j]) g = j;
      end
    end
    if (g >= 0) expRdy[g] = 1'b1;
    checkVal("req_ready", 64'(bus.req_ready), 64'(expRdy));
    checkVal("busy", 64'(bus.busy), 64'(modelBusy));
    if (bus.resp_valid) begin
      if (sb.size() == 0) begin
        checkVal("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = sb[0];
        if (!sawValid) begin
          checkVal("latency", 64'(cyc - e.acceptCyc), 64'(e.lat));
          sawValid = 1'b1;
        end
        checkVal("resp_id", 64'(bus.resp_id), 64'(e.id));
        checkVal("resp_result", bus.resp_result, e.res);
        checkVal("resp_carry", 64'(bus.resp_carry), 64'(e.c));
        checkVal("resp_zero", 64'(bus.resp_zero), 64'(e.z));
        checkVal("resp_negative", 64'(bus.resp_negative), 64'(e.n));
        if (bus.resp_ready) begin
          void'(sb.pop_front());
          sawValid  = 1'b0;
          modelBusy = 1'b0;
          respCnt++;
        end
      end
    end
    if (g >= 0) begin
      e = model(g, bus.req_op[2*g +: 2], bus.req_size[2*g +: 2], bus.req_use_carry[g],
                bus.req_carry_in[g], bus.req_a[64*g +: 64], bus.req_b[8*g +: 8]);
      e.acceptCyc = cyc + 1;
      sb.push_back(e);
      modelBusy = 1'b1;
      modelPtr  = 2'((g == RC - 1) ? 0 : g + 1);
      acceptCnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int idx, input logic [1:0] op, input logic [1:0] size,
                        input logic uc, input logic cin, input logic [63:0] a,
                        input logic [7:0] b);
    bus.req_op[2*idx +: 2]   = op;
    bus.req_size[2*idx +: 2] = size;
    bus.req_use_carry[idx]   = uc;
    bus.req_carry_in[idx]    = cin;
    bus.req_a[64*idx +: 64]  = a;
    bus.req_b[8*idx +: 8]    = b;
    bus.req_valid[idx]       = 1'b1;
  endtask

  task automatic waitAccepts(input int target, input int bound);
    int k;
    k = 0;
    while (acceptCnt < target && k < bound) begin
      tick();
      k++;
    end
    if (acceptCnt < target) checkVal("accept_timeout", 64'(acceptCnt), 64'(target));
  endtask

  task automatic waitResps(input int target, input int bound);
    int k;
    k = 0;
    while (respCnt < target && k < bound) begin
      tick();
      k++;
    end
    if (respCnt < target) checkVal("resp_timeout", 64'(respCnt), 64'(target));
  endtask

  task automatic runOne(input int idx, input logic [1:0] op, input logic [1:0] size,
                        input logic uc, input logic cin, input logic [63:0] a,
                        input logic [7:0] b);
    int baseA, baseR;
    baseA = acceptCnt;
    baseR = respCnt;
    setReq(idx, op, size, uc, cin, a, b);
    waitAccepts(baseA + 1, 20);
    bus.req_valid[idx] = 1'b0;
    waitResps(baseR + 1, 200);
  endtask

  initial begin
    logic [7:0] bTab [16];
    int baseA, baseR, k;
    bTab = '{8'd0, 8'd1, 8'd7, 8'd8, 8'd9, 8'd15, 8'd16, 8'd17,
             8'd31, 8'd32, 8'd33, 8'd63, 8'd64, 8'd65, 8'd200, 8'd255};

    reset             = 1'b1;
    bus.req_valid     = '1;
    bus.req_op        = '0;
    bus.req_size      = '0;
    bus.req_use_carry = '0;
    bus.req_carry_in  = '0;
    bus.req_a         = '0;
    bus.req_b         = '0;
    bus.resp_ready    = 1'b1;

    @(posedge clk);
    #1;
    checkVal("rst_req_ready", 64'(bus.req_ready), 64'd0);
    checkVal("rst_busy", 64'(bus.busy), 64'd0);
    checkVal("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    checkVal("rst_resp_result", bus.resp_result, 64'd0);
    checkVal("rst_resp_id", 64'(bus.resp_id), 64'd0);
    checkVal("rst_flags", 64'({bus.resp_zero, bus.resp_carry, bus.resp_negative}), 64'd0);
    bus.req_valid = '0;
    reset         = 1'b0;

    // Directed examples
    runOne(0, 2'b00, 2'd0, 1'b0, 1'b0, 64'h81, 8'd1);
    runOne(1, 2'b11, 2'd1, 1'b1, 1'b1, 64'h8000, 8'd1);
    runOne(0, 2'b10, 2'd3, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567, 8'd200);
    runOne(1, 2'b01, 2'd2, 1'b0, 1'b1, 64'h8000_0001, 8'd0);

    // Both requesters held valid: grants must alternate
    baseA = acceptCnt;
    baseR = respCnt;
    setReq(0, 2'b01, 2'd0, 1'b0, 1'b0, 64'h5A, 8'd3);
    setReq(1, 2'b10, 2'd2, 1'b1, 1'b1, 64'h1234_5678, 8'd4);
    waitAccepts(baseA + 4, 400);
    bus.req_valid = '0;
    waitResps(baseR + 4, 200);

    // Mixed patterns across counts, sizes and carry modes
    for (int i = 0; i < 16; i++) begin
      logic [63:0] a;
      a = (i == 3) ? 64'd0 : {$urandom, $urandom};
      runOne(i % 2, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, bTab[i]);
    end

    // Stall in DONE with another request pending
    baseA = acceptCnt;
    baseR = respCnt;
    bus.resp_ready = 1'b0;
    setReq(0, 2'b11, 2'd2, 1'b0, 1'b0, 64'hF0F0_1234, 8'd5);
    waitAccepts(baseA + 1, 20);
    bus.req_valid[0] = 1'b0;
    setReq(1, 2'b00, 2'd1, 1'b1, 1'b1, 64'hA5C3, 8'd20);
    k = 0;
    while (!sawValid && k < 100) begin
      tick();
      k++;
    end
    checkVal("stall_resp_seen", 64'(sawValid), 64'd1);
    repeat (5) tick();
    bus.resp_ready = 1'b1;
    waitAccepts(baseA + 2, 5);
    bus.req_valid[1] = 1'b0;
    waitResps(baseR + 2, 200);

    // Reset during RUN discards the operation
    baseA = acceptCnt;
    setReq(0, 2'b10, 2'd3, 1'b1, 1'b0, 64'hFFFF_0000_FFFF_0000, 8'd64);
    waitAccepts(baseA + 1, 20);
    bus.req_valid[0] = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    bus.req_valid[1] = 1'b1;
    #1;
    checkVal("midrun_rst_busy", 64'(bus.busy), 64'd0);
    checkVal("midrun_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    checkVal("midrun_rst_req_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
    repeat (80) tick();

    // Pointer back at 0 after reset
    baseA = acceptCnt;
    baseR = respCnt;
    setReq(0, 2'b00, 2'd1, 1'b0, 1'b0, 64'h0001, 8'd4);
    setReq(1, 2'b11, 2'd0, 1'b0, 1'b0, 64'h81, 8'd8);
    waitAccepts(baseA + 2, 100);
    bus.req_valid = '0;
    waitResps(baseR + 2, 200);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
